// File: rtl/spm_host_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spm_host_pkg
//  Description : Shared types and helpers for the spm host controller:
//                FSM state encoding, counter-width and product-width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package spm_host_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Product width for a given operand width.
  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // The counter has to hold the terminal count 2*WIDTH+P_LAT-1. Sizing for
  // 2*WIDTH+P_LAT+1 values leaves one value of headroom.
  function automatic int cnt_w(input int width, input int p_lat);
    return $clog2(2 * width + p_lat + 1);
  endfunction

endpackage : spm_host_pkg
`default_nettype wire

// File: rtl/spm_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spm_host_ctrl_if
//  Description : Bus-side operand/product handshake bundle.
//                master : requester (drives operands, consumes product)
//                slave  : controller (accepts operands, returns product)
//  Signals     : in_valid/in_ready/in_x/in_y     operand pair channel
//                out_valid/out_ready/out_p       product channel
//  Revision    : 1.0  initial release
// ============================================================================
interface spm_host_ctrl_if
  import spm_host_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  localparam int PROD_W = prod_w(WIDTH);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_x;
  logic [WIDTH-1:0]  in_y;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_p;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface : spm_host_ctrl_if
`default_nettype wire

// File: rtl/spm_host_ctrl_sr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : spm_sr_unit
//  Description : Shift registers of the spm host controller.
//                y PISO : parallel load, arithmetic right shift, LSB out.
//                p SIPO : bits enter at the MSB and move toward bit 0, so
//                         after 2*WIDTH shifts the first bit sits at bit 0.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                load_i         load y_load_i into the y register
//                shift_i        arithmetic shift of the y register
//                p_shift_i      shift p_bit_i into the p register
//                y_load_i       multiplier value to load
//                p_bit_i        serial product bit from spm
//                y_bit_o        current y LSB (serial out)
//                p_par_o        collected product (parallel out)
//  Revision    : 1.0  initial release
// ============================================================================
module spm_sr_unit
  import spm_host_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic                     p_shift_i,
  input  logic [WIDTH-1:0]         y_load_i,
  input  logic                     p_bit_i,
  output logic                     y_bit_o,
  output logic [prod_w(WIDTH)-1:0] p_par_o
);

  localparam int PROD_W = prod_w(WIDTH);

  logic [WIDTH-1:0]  y_sr_q, y_sr_d;
  logic [PROD_W-1:0] p_sr_q, p_sr_d;

  always_comb begin
    y_sr_d = y_sr_q;
    if (load_i) begin
      y_sr_d = y_load_i;
    end else if (shift_i) begin
      // Replicating the MSB keeps presenting the sign bit once the
      // original bits are used up, i.e. y is sign-extended to 2*WIDTH.
      y_sr_d = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    p_sr_d = p_sr_q;
    if (p_shift_i) begin
      p_sr_d = {p_bit_i, p_sr_q[PROD_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_sr_q <= '0;
      p_sr_q <= '0;
    end else begin
      y_sr_q <= y_sr_d;
      p_sr_q <= p_sr_d;
    end
  end

  assign y_bit_o = y_sr_q[0];
  assign p_par_o = p_sr_q;

endmodule : spm_sr_unit
`default_nettype wire

// File: rtl/spm_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spm_host_ctrl
//  Description : Host-side controller for the serial-parallel multiplier.
//                Accepts a signed operand pair, holds x in parallel, streams
//                y LSB-first (sign-extended) and collects the 2*WIDTH-bit
//                product, which is returned over a valid/ready handshake.
//  Ports       : clk, rst     clock, synchronous active-high reset
//                host         operand/product handshake (slave side)
//                spm_x_o      parallel multiplicand to spm
//                spm_y_o      serial multiplier bit to spm
//                spm_clr_o    one-cycle spm flush before each operation
//                spm_p_i      serial product bit from spm
//  Revision    : 1.0  initial release
// ============================================================================
module spm_host_ctrl
  import spm_host_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int P_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  spm_host_ctrl_if.slave   host,
  output logic [WIDTH-1:0] spm_x_o,
  output logic             spm_y_o,
  output logic             spm_clr_o,
  input  logic             spm_p_i
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int CNT_W  = cnt_w(WIDTH, P_LAT);
  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(2 * WIDTH + P_LAT - 1);
  localparam logic [CNT_W-1:0] c_PLAT    = CNT_W'(P_LAT);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  spm_x_q, spm_x_d;

  logic              w_load;
  logic              w_shift;
  logic              w_p_shift;
  logic              w_p_window;
  logic              w_y_bit;
  logic [PROD_W-1:0] w_p_par;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_spm_clr;
  logic              w_spm_y;

  // Product bits only start arriving P_LAT cycles into SHIFT.
  generate
    if (P_LAT == 0) begin : g_plat_zero
      assign w_p_window = 1'b1;
    end else begin : g_plat_nonzero
      assign w_p_window = (cnt_q >= c_PLAT);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spm_x_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spm_x_q <= spm_x_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spm_x_d     = spm_x_q;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_p_shift   = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_spm_clr   = 1'b0;
    w_spm_y     = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_in_ready = 1'b1;
        if (host.in_valid) begin
          w_load  = 1'b1;
          spm_x_d = host.in_x;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        w_spm_clr = 1'b1;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        w_spm_y   = w_y_bit;
        w_shift   = 1'b1;
        w_p_shift = w_p_window;
        if (cnt_q == c_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (host.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  spm_sr_unit #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .shift_i   (w_shift),
    .p_shift_i (w_p_shift),
    .y_load_i  (host.in_y),
    .p_bit_i   (spm_p_i),
    .y_bit_o   (w_y_bit),
    .p_par_o   (w_p_par)
  );

  // The product bus is forced to zero outside DONE so a partially collected
  // product is never visible.
  assign host.in_ready  = w_in_ready;
  assign host.out_valid = w_out_valid;
  assign host.out_p     = w_out_valid ? w_p_par : '0;
  assign spm_x_o        = spm_x_q;
  assign spm_y_o        = w_spm_y;
  assign spm_clr_o      = w_spm_clr;

endmodule : spm_host_ctrl
`default_nettype wire
